pdu_dmem_burst_master: RTL and testbench
========================================

Name: pdu_dmem_burst_master

Overview:
- Initiator side of the PDU data-memory interface; drives `interface_addr` / `interface_we` / `interface_wdata` and consumes `interface_rdata`.
- Converts one host command (start address, word count, direction) into a burst of single-word memory accesses.
- Streams write data in and read data out over valid/ready channels.
- Sits between the PDU command/UART engine and the data memory; used for memory dump/load without CPU involvement.

Parameters:
- DEPTH, 12: memory address width in words; must match the memory's DEPTH.
- LEN_W, 12: width of the burst-length field; burst size = cmd_len+1 words.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  DEPTH  start word address.
- cmd_len  in  LEN_W  words minus one.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  high only in WRITE.
- wr_data  in  32  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  32  read word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at burst completion.
- interface_addr  out  DEPTH  memory address.
- interface_rdata  in  32  memory read data; valid the cycle after the address is presented.
- interface_wdata  out  32  memory write data.
- interface_we  out  1  memory write enable.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; cmd_ready=1 after release.
  - wr_ready=0, rd_valid=0, busy=0, done=0, interface_we=0, interface_addr=0.
  - Read buffer emptied; in-flight flag cleared.
- Registers: cur_addr (DEPTH bits), remaining (LEN_W bits), inflight (1 bit), 2-entry read buffer.
- IDLE:
  - On cmd_valid&cmd_ready, latch cur_addr=cmd_addr and remaining=cmd_len.
  - Go to WRITE if cmd_write, else READ.
- WRITE:
  - wr_ready=1.
  - Outputs are combinational: interface_we=wr_valid, interface_wdata=wr_data, interface_addr=cur_addr. Memory writes on the same edge as the handshake.
  - Per handshake: cur_addr+1 (mod 2^DEPTH), remaining-1.
  - Handshake with remaining==0 -> DONE.
  - wr_valid low: no write, no state change.
- READ:
  - Issue a read (interface_addr=cur_addr, interface_we=0) when buffer occupancy + inflight < 2.
  - Issue sets inflight for the next cycle; that cycle interface_rdata is pushed into the buffer.
  - Each issue: cur_addr+1, remaining-1.
  - Issue with remaining==0 -> DRAIN.
  - Without an issue, interface_addr holds cur_addr (harmless read).
- DRAIN: no new issues; -> DONE when inflight==0 and buffer empty.
- DONE: done=1 for exactly one cycle, busy=1; -> IDLE.
- Read buffer:
  - rd_valid = buffer not empty; rd_data = head entry.
  - Pop on rd_valid&rd_ready.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Never overflows under any rd_ready pattern.
  - Zero-bubble throughput: 1 word/cycle when rd_ready is held high.
- Read latency: first rd_valid 2 cycles after the command handshake (issue at t+1, data at t+2).
- Address wraps from 2^DEPTH-1 to 0; no error is flagged.
- cmd_len at its maximum value transfers 2^LEN_W words. Addresses wrap if this exceeds the memory size.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset mid-burst: the burst is aborted immediately, the buffer is discarded, and no further writes occur. Memory words already written are kept.
- interface_we is never high outside WRITE.

Optional Feature:
- Macro: PDU_DMEM_BURST_CHECKSUM_EN.
- When defined:
  - Adds output port checksum[31:0].
  - 32-bit wrapping sum of every word transferred: write handshakes, or read pops.
  - Cleared on command accept; final value stable from the done pulse until the next command accept.
  - Reset value 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pdu_dmem_burst_pkg holds:
  - the state encoding: IDLE, WRITE, READ, DRAIN, DONE;
  - the buffer depth constant RD_BUF_DEPTH=2.
- One sub-module: pdu_dmem_rd_buf. A 2-entry synchronous FIFO with push/pop/full/empty/count, same clock and reset.

Test Plan:
- Write at 0x010, len=3, data 0xA0..0xA3 with wr_valid gaps, then read back with rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 back-to-back; done pulses once per burst.
- Read at 0xFFE, len=3 -> interface_addr sequence 0xFFE,0xFFF,0x000,0x001; rd_data matches preloaded contents.
- Read len=7 with rd_ready toggling 1-of-3 cycles -> all 8 words delivered in order, none lost or duplicated; interface_addr issues stall while the buffer is full.
- Assert cmd_valid with a different command during a write burst -> ignored; cmd_ready=0 until the cycle after done.
- Drop sys_rstn during the 3rd word of an 8-word write -> outputs reach reset values immediately; words 0-1 are written, word 2 onward is not; a subsequent command runs normally.
- With PDU_DMEM_BURST_CHECKSUM_EN, write 0xFFFFFFFF,0x00000002 -> checksum=0x00000001 at done.

Source files
------------

// File: rtl/pdu_dmem_burst_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pdu_dmem_burst_pkg - shared state encoding and read-buffer sizing
// Revision: 1.0
// -----------------------------------------------------------------------------
package pdu_dmem_burst_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_WRITE = 3'd1;
    localparam logic [STATE_W-1:0] S_READ  = 3'd2;
    localparam logic [STATE_W-1:0] S_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

    localparam int RD_BUF_DEPTH = 2;
    localparam int RD_BUF_PTR_W = $clog2(RD_BUF_DEPTH);
    localparam int RD_BUF_CNT_W = $clog2(RD_BUF_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/pdu_dmem_rd_buf.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pdu_dmem_rd_buf - small synchronous FIFO holding returned read words
// Revision: 1.0
// -----------------------------------------------------------------------------
module pdu_dmem_rd_buf
    import pdu_dmem_burst_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    sys_clk,
    input  logic                    sys_rstn,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [RD_BUF_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]        mem_q [RD_BUF_DEPTH];
    logic [RD_BUF_PTR_W-1:0] wr_ptr_q;
    logic [RD_BUF_PTR_W-1:0] rd_ptr_q;
    logic [RD_BUF_CNT_W-1:0] count_q;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (count_q == RD_BUF_CNT_W'(RD_BUF_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is fine when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + RD_BUF_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + RD_BUF_PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + RD_BUF_CNT_W'(1);
                2'b01:   count_q <= count_q - RD_BUF_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pdu_dmem_burst_master.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pdu_dmem_burst_master - turns one host command into a burst of single-word
// DMEM accesses; running checksum port under PDU_DMEM_BURST_CHECKSUM_EN.
// Revision: 1.0
// -----------------------------------------------------------------------------
module pdu_dmem_burst_master
    import pdu_dmem_burst_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int LEN_W = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [DEPTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] interface_addr,
    input  logic [31:0]      interface_rdata,
    output logic [31:0]      interface_wdata,
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    output logic             interface_we
);

    logic [STATE_W-1:0]      state_q,     state_d;
    logic [DEPTH-1:0]        cur_addr_q,  cur_addr_d;
    logic [LEN_W-1:0]        remaining_q, remaining_d;
    logic                    inflight_q,  inflight_d;

    logic                    buf_full;
    logic                    buf_empty;
    logic [RD_BUF_CNT_W-1:0] buf_count;
    logic [31:0]             buf_head;
    logic                    wr_fire;
    logic                    rd_pop;
    logic                    rd_issue;
    logic [RD_BUF_CNT_W:0]   slots_used;

    pdu_dmem_rd_buf #(
        .WIDTH (32)
    ) u_rd_buf (
        .sys_clk     (sys_clk),
        .sys_rstn    (sys_rstn),
        .push_i      (inflight_q),
        .push_data_i (interface_rdata),
        .pop_i       (rd_pop),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign wr_fire = (state_q == S_WRITE) && wr_valid;
    assign rd_pop  = !buf_empty && rd_ready;

    // A slot freed by this cycle's pop is credited immediately so a held-high
    // rd_ready streams one word per cycle without a bubble.
    assign slots_used = {1'b0, buf_count}
                      + (RD_BUF_CNT_W+1)'(inflight_q)
                      - (RD_BUF_CNT_W+1)'(rd_pop);
    assign rd_issue   = (state_q == S_READ)
                      && (!buf_full || rd_pop)
                      && (slots_used < (RD_BUF_CNT_W+1)'(RD_BUF_DEPTH));

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        inflight_d  = rd_issue;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    cur_addr_d  = cur_addr_q + DEPTH'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    cur_addr_d  = cur_addr_q + DEPTH'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && buf_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    assign cmd_ready       = (state_q == S_IDLE);
    assign wr_ready        = (state_q == S_WRITE);
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign rd_valid        = !buf_empty;
    assign rd_data         = buf_head;
    assign interface_addr  = cur_addr_q;
    assign interface_we    = wr_fire;
    assign interface_wdata = (state_q == S_WRITE) ? wr_data : 32'h0;

`ifdef PDU_DMEM_BURST_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == S_IDLE) && cmd_valid) begin
            checksum_d = 32'h0;
        end else if (wr_fire) begin
            checksum_d = checksum_q + wr_data;
        end else if (rd_pop) begin
            checksum_d = checksum_q + buf_head;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            checksum_q <= 32'h0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pdu_dmem_burst_master.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pdu_dmem_burst_master - scoreboard bench with a behavioural DMEM model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_pdu_dmem_burst_master;

    logic        sys_clk;
    logic        sys_rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [11:0] cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [11:0] interface_addr;
    logic [31:0] interface_rdata;
    logic [31:0] interface_wdata;
    logic        interface_we;
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem    [0:4095];
    logic [31:0] shadow [0:4095];
    logic [31:0] wq        [$];
    logic [31:0] rd_exp_q  [$];

    pdu_dmem_burst_master #(
        .DEPTH (12),
        .LEN_W (12)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rstn        (sys_rstn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .interface_addr  (interface_addr),
        .interface_rdata (interface_rdata),
        .interface_wdata (interface_wdata),
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
        .checksum        (checksum),
`endif
        .interface_we    (interface_we)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous DMEM: write on the edge, read data valid the next cycle.
    always @(posedge sys_clk) begin
        if (interface_we) begin
            mem[interface_addr] <= interface_wdata;
        end
        interface_rdata <= mem[interface_addr];
    end

    task automatic run_write(input logic [11:0] addr, input logic [11:0] len,
                             input bit gaps, input bit intrude);
        int          idx = 0;
        int          cyc = 0;
        logic [11:0] a   = addr;
        logic [31:0] sum = 32'h0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
        end
        @(negedge sys_clk);
        cmd_valid = intrude; cmd_write = 1'b0; cmd_addr = 12'h123; cmd_len = 12'h5;
        while (idx <= int'(len) && cyc < 200) begin
            wr_valid = !(gaps && (cyc % 3 == 1));
            wr_data  = wq[idx];
            #1;
            checks++;
            if ({wr_ready, cmd_ready, busy, done} !== 4'b1010) begin
                failures++;
                $display("FAIL wr_status got=%b exp=1010", {wr_ready, cmd_ready, busy, done});
            end
            checks++;
            if (wr_valid) begin
                if (interface_we !== 1'b1 || interface_addr !== a || interface_wdata !== wq[idx]) begin
                    failures++;
                    $display("FAIL wr_access got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                             interface_we, interface_addr, interface_wdata, a, wq[idx]);
                end
                shadow[a] = wq[idx];
                sum += wq[idx];
                a++;
                idx++;
            end else if (interface_we !== 1'b0) begin
                failures++; $display("FAIL wr_gap_we got=%b exp=0", interface_we);
            end
            @(negedge sys_clk);
            cyc++;
        end
        wr_valid = 1'b0;
        if (idx <= int'(len)) begin
            checks++; failures++;
            $display("FAIL wr_timeout got=%0d exp=%0d", idx, int'(len) + 1);
        end
        #1;
        checks++;
        if ({done, busy, cmd_ready, wr_ready, interface_we} !== 5'b11000) begin
            failures++;
            $display("FAIL wr_done got=%b exp=11000", {done, busy, cmd_ready, wr_ready, interface_we});
        end
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
            failures++; $display("FAIL wr_checksum got=%h exp=%h", checksum, sum);
        end
`endif
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if ({done, busy, cmd_ready} !== 3'b001) begin
            failures++; $display("FAIL wr_idle got=%b exp=001", {done, busy, cmd_ready});
        end
    endtask

    task automatic run_read(input logic [11:0] addr, input logic [11:0] len, input bit slow);
        int          issued    = 0;
        int          popped    = 0;
        int          cyc       = 0;
        bit          seen_done = 1'b0;
        logic [31:0] sum       = 32'h0;
        logic [31:0] exp_word;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i <= int'(len); i++) begin
            rd_exp_q.push_back(shadow[addr + 12'(i)]);
        end
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL rd_cmd_ready got=%b exp=1", cmd_ready);
        end
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        while (!seen_done && cyc < 400) begin
            rd_ready = slow ? (cyc % 3 == 2) : 1'b1;
            #1;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if ({rd_valid, busy, cmd_ready} !== 3'b010) begin
                    failures++;
                    $display("FAIL rd_done got=%b exp=010", {rd_valid, busy, cmd_ready});
                end
            end else begin
                if (issued <= int'(len) && interface_addr === addr + 12'(issued + 1)) begin
                    issued++;
                end
                checks++;
                if (interface_addr !== addr + 12'(issued)) begin
                    failures++;
                    $display("FAIL rd_addr got=%h exp=%h", interface_addr, addr + 12'(issued));
                end
                checks++;
                if ({interface_we, cmd_ready, busy} !== 3'b001) begin
                    failures++;
                    $display("FAIL rd_status got=%b exp=001", {interface_we, cmd_ready, busy});
                end
                checks++;
                if (issued - popped > 2) begin
                    failures++;
                    $display("FAIL rd_outstanding got=%0d exp<=2", issued - popped);
                end
                if (cyc < 2) begin
                    checks++;
                    if (rd_valid !== 1'b0) begin
                        failures++; $display("FAIL rd_latency cyc=%0d got=%b exp=0", cyc, rd_valid);
                    end
                end else if (!slow && cyc <= int'(len) + 2) begin
                    checks++;
                    if (rd_valid !== 1'b1) begin
                        failures++; $display("FAIL rd_bubble cyc=%0d got=%b exp=1", cyc, rd_valid);
                    end
                end
                if (rd_valid === 1'b1 && rd_ready) begin
                    checks++;
                    if (rd_exp_q.size() == 0) begin
                        failures++; $display("FAIL rd_extra got=%h exp=none", rd_data);
                    end else begin
                        exp_word = rd_exp_q.pop_front();
                        if (rd_data !== exp_word) begin
                            failures++; $display("FAIL rd_data got=%h exp=%h", rd_data, exp_word);
                        end
                    end
                    sum += rd_data;
                    popped++;
                end
                @(negedge sys_clk);
                cyc++;
            end
        end
        if (!seen_done) begin
            checks++; failures++;
            $display("FAIL rd_timeout got=no_done exp=done");
        end
        checks++;
        if (rd_exp_q.size() != 0 || issued != int'(len) + 1) begin
            failures++;
            $display("FAIL rd_count got left=%0d issued=%0d exp left=0 issued=%0d",
                     rd_exp_q.size(), issued, int'(len) + 1);
        end
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
            failures++; $display("FAIL rd_checksum got=%h exp=%h", checksum, sum);
        end
`endif
        rd_exp_q.delete();
        rd_ready = 1'b0;
        @(negedge sys_clk);
        #1;
        checks++;
        if ({done, busy, cmd_ready} !== 3'b001) begin
            failures++; $display("FAIL rd_idle got=%b exp=001", {done, busy, cmd_ready});
        end
    endtask

    task automatic test_reset;
        sys_rstn = 1'b0;
        repeat (2) @(negedge sys_clk);
        #1;
        checks++;
        if ({wr_ready, rd_valid, busy, done, interface_we} !== 5'b0 || interface_addr !== 12'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b addr=%h exp=00000 addr=000",
                     {wr_ready, rd_valid, busy, done, interface_we}, interface_addr);
        end
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            failures++; $display("FAIL reset_checksum got=%h exp=0", checksum);
        end
`endif
        @(negedge sys_clk);
        sys_rstn = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            failures++; $display("FAIL reset_release got=%b exp=10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write_readback;
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + i);
        run_write(12'h010, 12'd3, 1'b1, 1'b0);
        run_read(12'h010, 12'd3, 1'b0);
    endtask

    task automatic test_addr_wrap;
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(32'hC0DE_0000 + i);
        run_write(12'hFFE, 12'd3, 1'b0, 1'b0);
        run_read(12'hFFE, 12'd3, 1'b0);
    endtask

    task automatic test_backpressure;
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(32'hD000_0000 + (i * 32'h111));
        run_write(12'h300, 12'd7, 1'b0, 1'b0);
        run_read(12'h300, 12'd7, 1'b1);
    endtask

    task automatic test_cmd_ignored;
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(32'hE000_0000 + i);
        run_write(12'h400, 12'd3, 1'b1, 1'b1);
        run_read(12'h400, 12'd3, 1'b0);
    endtask

    task automatic test_reset_mid_burst;
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(32'h5500_0000 + i);
        run_write(12'h200, 12'd3, 1'b0, 1'b0);
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h200; cmd_len = 12'd7;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hB0 + k;
            if (k < 2) begin
                shadow[12'h200 + 12'(k)] = 32'hB0 + k;
            end else begin
                #1;
                sys_rstn = 1'b0;
                #1;
                checks++;
                if ({wr_ready, rd_valid, busy, done, interface_we} !== 5'b0 || interface_addr !== 12'h0) begin
                    failures++;
                    $display("FAIL midreset_outputs got=%b addr=%h exp=00000 addr=000",
                             {wr_ready, rd_valid, busy, done, interface_we}, interface_addr);
                end
            end
            @(negedge sys_clk);
        end
        wr_valid = 1'b0;
        sys_rstn = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            failures++; $display("FAIL midreset_release got=%b exp=10", {cmd_ready, busy});
        end
        run_read(12'h200, 12'd3, 1'b0);
    endtask

    task automatic test_checksum;
`ifdef PDU_DMEM_BURST_CHECKSUM_EN
        wq.delete();
        wq.push_back(32'hFFFF_FFFF);
        wq.push_back(32'h0000_0002);
        run_write(12'h500, 12'd1, 1'b0, 1'b0);
        checks++;
        if (checksum !== 32'h0000_0001) begin
            failures++; $display("FAIL checksum_wrap got=%h exp=00000001", checksum);
        end
`endif
    endtask

    initial begin
        sys_rstn  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 12'h0;
        cmd_len   = 12'h0;
        wr_valid  = 1'b0;
        wr_data   = 32'h0;
        rd_ready  = 1'b0;
        test_reset();
        test_write_readback();
        test_addr_wrap();
        test_backpressure();
        test_cmd_ignored();
        test_reset_mid_burst();
        test_checksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
